// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
//
// Pipelined WIDTH-bit adder/subtractor. The operation is split into STAGES
// chunks of C = WIDTH/STAGES bits. Stage k adds chunk k using the carry that
// stage k-1 registered, so each clock only ripples across C bits. The upper
// operand chunks that are still waiting travel forward in skew registers. The
// finished lower sum chunks travel forward in deskew registers. The full
// result is aligned in the last stage.
//
// One beat can be accepted per clock. A single global enable stalls the whole
// pipeline whenever the output holds a beat that the sink has not taken.
//
// Parameters:
//   WIDTH   operand/result width, must be a multiple of STAGES
//   STAGES  pipeline depth and number of chunks (1 <= STAGES <= WIDTH)
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle (combinational, = global enable)
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0 = a + b + cin, 1 = a - b - cin
//   out_valid  result beat valid
//   out_ready  sink accepts result
//   sum        result
//   cout       carry-out; for subtract, 1 means no borrow
//   ovf        signed overflow
// -----------------------------------------------------------------------------

// One C-bit slice of the carry chain (purely combinational).
module pipe_adder_chunk #(
   parameter int C = 16
) (
   input  logic [C-1:0] a_i,
   input  logic [C-1:0] b_i,
   input  logic         c_i,
   output logic [C-1:0] s_o,
   output logic         c_o
);
   assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{C{1'b0}}, c_i};
endmodule

module pipe_adder #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int C = WIDTH / STAGES;

   logic              en;
   logic [WIDTH-1:0]  b_eff;
   logic              c0;
   logic [STAGES-1:0] vin;          // upstream valid seen by each stage
   logic [STAGES-1:0] vld_pipe_q;
   logic [STAGES-1:0] vld_pipe_d;

   // The whole pipe moves together. It may advance unless the output holds a
   // beat that the sink refuses.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // Subtraction is a + ~b + ~cin. The operand and carry are conditioned
   // here, so each beat carries its own mode down the pipe.
   assign b_eff = sub ? ~b : b;
   assign c0    = sub ? ~cin : cin;

   always_comb begin
      vin    = '0;
      vin[0] = in_valid;
      for (int k = 1; k < STAGES; k++) vin[k] = vld_pipe_q[k-1];
      vld_pipe_d = en ? vin : vld_pipe_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_pipe_q <= '0;
      else        vld_pipe_q <= vld_pipe_d;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      // Operand bits that are not yet consumed when this stage runs.
      localparam int SRCW = WIDTH - k*C;

      logic [SRCW-1:0]      a_src;
      logic [SRCW-1:0]      b_src;
      logic                 c_src;
      logic [C-1:0]         s_ck;
      logic                 c_ck;
      logic [(k+1)*C-1:0]   s_d;
      logic [(k+1)*C-1:0]   s_q;    // deskewed low sum chunks
      logic                 c_q;
      logic                 ld;

      // Data registers load only when a real beat arrives. During bubbles the
      // last result stays visible and no X values reach the outputs.
      assign ld = en && vin[k];

      if (k == 0) begin : g_head
         assign a_src = a;
         assign b_src = b_eff;
         assign c_src = c0;
         assign s_d   = s_ck;
      end else begin : g_body
         assign a_src = g_stg[k-1].g_skew.a_sk_q;
         assign b_src = g_stg[k-1].g_skew.b_sk_q;
         assign c_src = g_stg[k-1].c_q;
         assign s_d   = {s_ck, g_stg[k-1].s_q};
      end

      pipe_adder_chunk #(.C(C)) u_chunk (
         .a_i (a_src[C-1:0]),
         .b_i (b_src[C-1:0]),
         .c_i (c_src),
         .s_o (s_ck),
         .c_o (c_ck)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s_q <= '0;
            c_q <= 1'b0;
         end else if (ld) begin
            s_q <= s_d;
            c_q <= c_ck;
         end
      end

      if (k < STAGES-1) begin : g_skew
         // The upper operand chunks wait here for their stage.
         logic [SRCW-C-1:0] a_sk_q;
         logic [SRCW-C-1:0] b_sk_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_sk_q <= '0;
               b_sk_q <= '0;
            end else if (ld) begin
               a_sk_q <= a_src[SRCW-1:C];
               b_sk_q <= b_src[SRCW-1:C];
            end
         end
      end else begin : g_tail
         // The MSB chunk is added here, so the signed-overflow check lives
         // here too. It uses the effective (possibly inverted) b operand.
         logic ovf_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  ovf_q <= 1'b0;
            else if (ld) ovf_q <= (a_src[SRCW-1] == b_src[SRCW-1]) &&
                                  (s_ck[C-1] != a_src[SRCW-1]);
         end
      end
   end

   assign out_valid = vld_pipe_q[STAGES-1];
   assign sum       = g_stg[STAGES-1].s_q;
   assign cout      = g_stg[STAGES-1].c_q;
   assign ovf       = g_stg[STAGES-1].g_tail.ovf_q;

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined successor to the team's single-cycle wide adder.
- Splits a WIDTH-bit add/subtract into STAGES carry-chained chunks, one chunk per register stage.
- Sustains one operation per clock with valid/ready flow control on both sides.
- Sits between the stimulus/file-driven front end and the result sink in the arithmetic datapath, and is verified against the golden model via the same text-vector flow.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and number of chunks; chunk width C = WIDTH/STAGES; 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A (unsigned/two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat valid.
- out_ready  input  1  sink accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out; in sub mode, 1 = no borrow.
- ovf  output  1  signed overflow flag.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0, all data/carry registers 0. Outputs: out_valid=0, sum=0, cout=0, ovf=0.
- in_ready is combinational and equals en; it may be high during reset release.
- Arithmetic:
  - add: {cout,sum} = a + b + cin.
  - sub: b_eff = ~b, c0 = ~cin; {cout,sum} = a + b_eff + c0, i.e. a - b - cin.
  - ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]).
- Pipeline:
  - Stage k (0..STAGES-1) adds chunk bits [k*C +: C] of a and b_eff using the carry registered by stage k-1 (stage 0 uses c0).
  - Unprocessed upper chunks are carried forward in skew registers; completed lower sum chunks are delayed forward in deskew registers.
  - Result is aligned at the last stage.
- Latency: exactly STAGES cycles from an accepted input beat (in_valid && in_ready on edge N) to out_valid=1 after edge N+STAGES-1, when no stall occurs.
- Flow control:
  - Global enable en = !out_valid || out_ready; in_ready = en.
  - When en=0 every stage register (data and valid) holds its value; sum/cout/ovf stay stable while out_valid && !out_ready.
  - When en=1 all stages advance; a stage whose upstream has no valid beat becomes a bubble (valid=0, data don't-care, but ovf/cout/sum keep last values only when out_valid=0 — no X required).
- Throughput: 1 beat/clk when out_ready held high. Beat ordering is strictly preserved; no beat is dropped or duplicated.
- Simultaneous events: an input accept and an output handshake in the same cycle are both honoured.
- sub and cin are captured with the beat and travel with it; changing sub on the next beat has no effect on earlier beats.
- Reset mid-operation: all in-flight beats are discarded immediately; no partial result is presented after rst_n returns high.
- STAGES=1: degenerates to a single registered full adder with latency 1.

Test Plan:
- Basic add, WIDTH=64/STAGES=4: a=0x0000_0000_0000_0005, b=0x3, cin=0, sub=0 -> 4 cycles later out_valid=1, sum=0x8, cout=0, ovf=0.
- Full carry ripple across all chunks: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1 add -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
- Subtract with borrow: a=5, b=7, sub=1, cin=0 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Also a=7, b=5, sub=1, cin=1 -> sum=1, cout=1.
- Backpressure: stream 8 beats a=i, b=i (i=0..7) with out_ready low for cycles 5-8 -> in_ready low during the stall, sum held stable, all 8 results 0,2,...,14 delivered in order.
- Reset mid-stream: assert rst_n low with 3 beats in flight -> out_valid=0 and sum=0 immediately; no stale beats appear after release. Additionally, random 10k-vector file compare vs golden model for STAGES in {1,2,4} and WIDTH in {8,64}.
